// File: rtl/digit_scan_if.sv
// Scan control bundle between the digit-scan sequencer and whatever drives it.
interface digit_scan_if;
    logic       run;
    logic [3:0] mask;
    logic [1:0] sel;
    logic       en;
    logic       tick;

    modport master (output run, mask, input sel, en, tick);
    modport slave  (input run, mask, output sel, en, tick);
endinterface

// File: rtl/digit_scan_ctrl.sv
// Digit scan sequencer: time-slotted SEL/EN/TICK for a 2-to-4 digit decoder.
// Define SCAN_SKIP_EN to skip masked digits instead of giving them a dark slot.
//
// state   | meaning
// IDLE    | not scanning, all outputs low
// BLANK   | anti-ghosting window at the start of a slot, EN low
// DRIVE   | remainder of the slot, EN follows the latched mask bit
module digit_scan_ctrl #(
    parameter int DIV        = 8,
    parameter int BLANK      = 2,
    parameter int NUM_DIGITS = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    digit_scan_if.slave  io_scan
);

    localparam int             CW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0]  BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [1:0]     SEL_LAST   = 2'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [1:0]     r_sel;
    logic           r_en;
    logic           r_tick;
    logic [3:0]     r_mask_q;

    state_t         w_state_nxt;
    logic           w_slot_start;
    logic [1:0]     w_sel_slot;
    logic [CW-1:0]  w_cnt_nxt;
    logic [1:0]     w_sel_nxt;
    logic           w_en_nxt;
    logic           w_tick_nxt;
    logic [3:0]     w_mask_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_sel    <= 2'd0;
            r_en     <= 1'b0;
            r_tick   <= 1'b0;
            r_mask_q <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sel    <= w_sel_nxt;
            r_en     <= w_en_nxt;
            r_tick   <= w_tick_nxt;
            r_mask_q <= w_mask_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_slot_start = 1'b0;
        if (!io_scan.run) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_slot_start = 1'b1;
                S_BLANK: if (r_cnt == BLANK_LAST) w_state_nxt = S_DRIVE;
                S_DRIVE: if (r_cnt == CNT_LAST) w_slot_start = 1'b1;
                default: w_state_nxt = S_IDLE;
            endcase
            if (w_slot_start) w_state_nxt = (BLANK > 0) ? S_BLANK : S_DRIVE;
        end
    end

`ifdef SCAN_SKIP_EN
    localparam logic [3:0] DIGIT_MASK = 4'((1 << NUM_DIGITS) - 1);
    logic [3:0] w_mask_eff;
    assign w_mask_eff = io_scan.mask & DIGIT_MASK;

    // Search starts one past the current digit; from IDLE, starting past the
    // last digit makes the lowest unmasked digit win.
    always_comb begin : p_sel_skip
        logic [1:0] w_cand;
        logic       w_found;
        w_cand     = (r_state == S_IDLE) ? SEL_LAST : r_sel;
        w_found    = 1'b0;
        w_sel_slot = (r_state == S_IDLE) ? 2'd0 : r_sel;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_cand = (w_cand == SEL_LAST) ? 2'd0 : w_cand + 2'd1;
            if (!w_found && w_mask_eff[w_cand]) begin
                w_found    = 1'b1;
                w_sel_slot = w_cand;
            end
        end
    end
`else
    assign w_sel_slot = (r_state == S_IDLE || r_sel == SEL_LAST) ? 2'd0 : r_sel + 2'd1;
`endif

    always_comb begin
        w_cnt_nxt  = r_cnt + 1'b1;
        w_sel_nxt  = r_sel;
        w_tick_nxt = 1'b0;
        w_mask_nxt = r_mask_q;
        w_en_nxt   = 1'b0;
        if (w_state_nxt == S_IDLE) begin
            w_cnt_nxt  = '0;
            w_sel_nxt  = 2'd0;
            w_mask_nxt = 4'd0;
        end else if (w_slot_start) begin
            w_cnt_nxt  = '0;
            w_sel_nxt  = w_sel_slot;
            w_tick_nxt = 1'b1;
            w_mask_nxt = io_scan.mask;
            w_en_nxt   = (w_state_nxt == S_DRIVE) && io_scan.mask[w_sel_slot];
        end else begin
            w_en_nxt   = (w_state_nxt == S_DRIVE) && r_mask_q[r_sel];
        end
    end

    assign io_scan.sel  = r_sel;
    assign io_scan.en   = r_en;
    assign io_scan.tick = r_tick;

endmodule
